// File: rtl/siso_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : siso_ctrl_pkg
//  Brief    : Shared state type and sizing helpers for the SISO shift
//             controller. Optional macro: SHIFT_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package siso_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

`ifdef SHIFT_PARITY_EN
   localparam bit c_parity_en = 1'b1;
`else
   localparam bit c_parity_en = 1'b0;
`endif

   // Counter sized for WIDTH+1 bit positions plus headroom.
   function automatic int cnt_width(input int n);
      return $clog2(n + 2);
   endfunction

   function automatic int frame_len(input int width, input bit parity);
      return width + (parity ? 1 : 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_bit_counter
//  Brief    : Clearable up-counter with a terminal-count flag.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_bit_counter
   import siso_ctrl_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;
   assign tc    = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/siso_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : siso_shift_ctrl
//  Brief    : Framed serializer driving a SISO shift chain from a valid/ready
//             word stream. Optional macro: SHIFT_PARITY_EN (trailing parity).
//  Revision : 1.0 - initial release
// ============================================================================
module siso_shift_ctrl
   import siso_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 1,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             flush,
   output logic             serial_out,
   output logic             shift_en,
   output logic             frame,
   output logic             done,
   output logic             busy
);

   localparam int                 c_cnt_w     = cnt_width(WIDTH);
   localparam int                 c_frame_len = frame_len(WIDTH, c_parity_en);
   localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(c_frame_len - 1);
   localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic [c_cnt_w-1:0] w_bit_count;
   logic               w_bit_tc;
   logic               w_bit_more;
   logic               w_gap_tc;
   logic [WIDTH-1:0]   r_shadow;
   logic [WIDTH-1:0]   w_shift_in;
   logic [WIDTH-1:0]   w_shift_sh;
   logic               w_first_in;
   logic               w_first_sh;
   logic               w_serial_nxt;
   logic               w_done_nxt;
   logic               r_serial;
   logic               r_shift_en;
   logic               r_frame;
   logic               r_done;
   logic               r_busy;
   logic               r_in_ready;

   assign w_accept = (r_state == IDLE) && in_valid && r_in_ready && !flush;

   // The shadow register always holds the not-yet-emitted bits aligned so the
   // next bit sits at the shift-out end; the first bit bypasses it at accept.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_first_in = in_data[WIDTH-1];
         assign w_shift_in = {in_data[WIDTH-2:0], 1'b0};
         assign w_first_sh = r_shadow[WIDTH-1];
         assign w_shift_sh = {r_shadow[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_first_in = in_data[0];
         assign w_shift_in = {1'b0, in_data[WIDTH-1:1]};
         assign w_first_sh = r_shadow[0];
         assign w_shift_sh = {1'b0, r_shadow[WIDTH-1:1]};
      end
   endgenerate

   shift_bit_counter #(
      .CNT_W (c_cnt_w)
   ) u_bit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_accept),
      .en    (r_state == SHIFT),
      .term  (c_last_bit),
      .count (w_bit_count),
      .tc    (w_bit_tc)
   );

   assign w_bit_more = (w_bit_count < c_last_data);

   generate
      if (GAP_CYCLES > 0) begin : g_gap
         localparam int c_gap_w = cnt_width(GAP_CYCLES);
         logic               w_gap_load;
         logic [c_gap_w-1:0] w_gap_cnt_unused;

         assign w_gap_load = (r_state == SHIFT) && w_bit_tc;

         shift_bit_counter #(
            .CNT_W (c_gap_w)
         ) u_gap_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (w_gap_load),
            .en    (r_state == GAP),
            .term  (c_gap_w'(GAP_CYCLES - 1)),
            .count (w_gap_cnt_unused),
            .tc    (w_gap_tc)
         );
      end else begin : g_no_gap
         assign w_gap_tc = 1'b1;
      end
   endgenerate

`ifdef SHIFT_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= ^in_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else if (w_accept) begin
         r_shadow <= w_shift_in;
      end else if (r_state == SHIFT) begin
         r_shadow <= w_shift_sh;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (flush) begin
               w_state_nxt = IDLE;
            end else if (w_bit_tc) begin
               w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (flush || w_gap_tc) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are computed for the upcoming state so they register in step with it.
   always_comb begin
      w_serial_nxt = 1'b0;
      w_done_nxt   = (r_state == SHIFT) && w_bit_tc && !flush;
      if (w_state_nxt == SHIFT) begin
         if (r_state == IDLE) begin
            w_serial_nxt = w_first_in;
         end else if (w_bit_more) begin
            w_serial_nxt = w_first_sh;
         end
`ifdef SHIFT_PARITY_EN
         else begin
            w_serial_nxt = r_parity;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready <= 1'b0;
         r_shift_en <= 1'b0;
         r_frame    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_serial   <= 1'b0;
      end else begin
         r_in_ready <= (w_state_nxt == IDLE);
         r_shift_en <= (w_state_nxt == SHIFT);
         r_frame    <= (w_state_nxt == SHIFT);
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= w_done_nxt;
         r_serial   <= w_serial_nxt;
      end
   end

   assign in_ready   = r_in_ready;
   assign shift_en   = r_shift_en;
   assign frame      = r_frame;
   assign busy       = r_busy;
   assign done       = r_done;
   assign serial_out = r_serial;

endmodule
`default_nettype wire

// File: tb/tb_siso_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_siso_shift_ctrl
//  Brief    : Two serializer instances (MSB-first/gap 1, LSB-first/gap 0) on
//             shared stimulus, checked against a bit-queue frame model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_siso_shift_ctrl;

   localparam int W = 8;
`ifdef SHIFT_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         flush = 1'b0;

   logic a_in_ready, a_serial, a_shift_en, a_frame, a_done, a_busy;
   logic b_in_ready, b_serial, b_shift_en, b_frame, b_done, b_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   siso_shift_ctrl #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(a_in_ready), .flush(flush), .serial_out(a_serial),
      .shift_en(a_shift_en), .frame(a_frame), .done(a_done), .busy(a_busy)
   );

   siso_shift_ctrl #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(b_in_ready), .flush(flush), .serial_out(b_serial),
      .shift_en(b_shift_en), .frame(b_frame), .done(b_done), .busy(b_busy)
   );

   // Model: per instance, the bits still to appear (current bit at index 0),
   // remaining gap cycles, a pending done flag and "seen an edge since reset".
   logic [W:0] m_word [2] = '{'0, '0};
   int         m_left [2] = '{0, 0};
   int         m_gap  [2] = '{0, 0};
   bit         m_done [2] = '{1'b0, 1'b0};
   bit         m_rdy  [2] = '{1'b0, 1'b0};

   function automatic int gap_of(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   function automatic logic [W:0] order_bits(input logic [W-1:0] d, input int i);
      logic [W:0] r;
      r = '0;
      for (int b = 0; b < W; b++) begin
         r[b] = (i == 0) ? d[W-1-b] : d[b];
      end
`ifdef SHIFT_PARITY_EN
      r[W] = ^d;
`endif
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_left[i] <= 0;
            m_gap[i]  <= 0;
            m_done[i] <= 1'b0;
            m_rdy[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_done[i] <= 1'b0;
            m_rdy[i]  <= 1'b1;
            if (m_left[i] > 0) begin
               if (flush) begin
                  m_left[i] <= 0;
               end else begin
                  m_word[i] <= m_word[i] >> 1;
                  m_left[i] <= m_left[i] - 1;
                  if (m_left[i] == 1) begin
                     m_done[i] <= 1'b1;
                     m_gap[i]  <= gap_of(i);
                  end
               end
            end else if (m_gap[i] > 0) begin
               m_gap[i] <= flush ? 0 : m_gap[i] - 1;
            end else if (m_rdy[i] && in_valid && !flush) begin
               m_word[i] <= order_bits(in_data, i);
               m_left[i] <= W + P;
            end
         end
      end
   end

   // {in_ready, done, busy, frame, shift_en, serial_out}
   function automatic logic [5:0] model_out(input int i);
      logic sh;
      logic bz;
      sh = (m_left[i] > 0);
      bz = sh || (m_gap[i] > 0);
      return {m_rdy[i] && !bz, m_done[i], bz, sh, sh, sh && m_word[i][0]};
   endfunction

   always @(negedge clk) begin
      logic [5:0] act;
      logic [5:0] exp;
      for (int i = 0; i < 2; i++) begin
         act = (i == 0) ? {a_in_ready, a_done, a_busy, a_frame, a_shift_en, a_serial}
                        : {b_in_ready, b_done, b_busy, b_frame, b_shift_en, b_serial};
         exp = model_out(i);
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL model_dut%0d t=%0t rdy/done/busy/frame/sh/ser got %b want %b",
                     i, $time, act, exp);
         end
      end
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   logic [W-1:0] a5_bits;

   initial begin
      a5_bits = 8'b1010_0101;   // emission order for A5, identical MSB- and LSB-first
      #1 rst_n = 1'b0;
      #1;
      chk("reset_a_in_ready", a_in_ready, 1'b0);
      chk("reset_b_busy", b_busy, 1'b0);
      step(2);
      rst_n = 1'b1;
      chk("pre_edge_in_ready", a_in_ready, 1'b0);
      step(1);
      chk("first_edge_in_ready_a", a_in_ready, 1'b1);
      chk("first_edge_in_ready_b", b_in_ready, 1'b1);

      // Frame A5, with an ignored valid pulse and data churn mid-frame.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step(1);
      in_valid = 1'b0;
      for (int k = 0; k < W; k++) begin
         chk($sformatf("a5_a_bit%0d", k + 1), a_serial, a5_bits[W-1-k]);
         chk($sformatf("a5_b_bit%0d", k + 1), b_serial, a5_bits[W-1-k]);
         chk($sformatf("a5_a_shen%0d", k + 1), a_shift_en, 1'b1);
         if (k == 2) begin
            in_valid = 1'b1;
            in_data  = 8'h00;
         end
         if (k == 3) begin
            in_valid = 1'b0;
            in_data  = 8'hFF;
         end
         step(1);
      end
`ifdef SHIFT_PARITY_EN
      chk("a5_parity_bit", a_serial, 1'b0);
      chk("a5_parity_shen", a_shift_en, 1'b1);
      step(1);
`endif
      chk("a5_a_done", a_done, 1'b1);
      chk("a5_a_not_ready_in_gap", a_in_ready, 1'b0);
      chk("a5_b_done", b_done, 1'b1);
      chk("a5_b_ready_with_done", b_in_ready, 1'b1);
      step(1);
      chk("a5_a_ready_after_gap", a_in_ready, 1'b1);
      chk("a5_a_done_single", a_done, 1'b0);

      // Held valid: A5 then 3C; instance b takes 3C with no bubble.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step(1);
      in_data = 8'h3C;
      step(8 + P);
      chk("b2b_b_done", b_done, 1'b1);
      chk("b2b_b_ready", b_in_ready, 1'b1);
      step(1);
      chk("b2b_b_shen", b_shift_en, 1'b1);
      chk("b2b_b_bit0", b_serial, 1'b0);
      step(1);
      in_valid = 1'b0;
      step(25);

      // Flush on cycle 4 of FF, then flush beats a handshake, then 01.
      in_valid = 1'b1;
      in_data  = 8'hFF;
      step(1);
      in_valid = 1'b0;
      step(3);
      flush = 1'b1;
      step(1);
      chk("flush_a_shen", a_shift_en, 1'b0);
      chk("flush_a_ready", a_in_ready, 1'b1);
      chk("flush_b_ready", b_in_ready, 1'b1);
      chk("flush_a_no_done", a_done, 1'b0);
      chk("flush_b_no_done", b_done, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h01;
      step(1);
      chk("flush_wins_ready", a_in_ready, 1'b1);
      chk("flush_wins_shen", a_shift_en, 1'b0);
      flush = 1'b0;
      step(1);
      in_valid = 1'b0;
      chk("w01_a_bit1", a_serial, 1'b0);
      chk("w01_b_bit1", b_serial, 1'b1);
      step(20);

      // Asynchronous reset on cycle 3 of C3.
      in_valid = 1'b1;
      in_data  = 8'hC3;
      step(1);
      in_valid = 1'b0;
      step(2);
      chk("pre_rst_a_shen", a_shift_en, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_a_shen", a_shift_en, 1'b0);
      chk("async_rst_a_frame", a_frame, 1'b0);
      chk("async_rst_a_busy", a_busy, 1'b0);
      chk("async_rst_b_shen", b_shift_en, 1'b0);
      chk("async_rst_b_busy", b_busy, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("rst_release_a_ready", a_in_ready, 1'b1);
      chk("rst_release_b_ready", b_in_ready, 1'b1);

      // Word 07: parity 1 when enabled, else done right after bit 8.
      in_valid = 1'b1;
      in_data  = 8'h07;
      step(1);
      in_valid = 1'b0;
      step(8);
`ifdef SHIFT_PARITY_EN
      chk("w07_parity_bit", a_serial, 1'b1);
      chk("w07_parity_shen", a_shift_en, 1'b1);
      step(1);
      chk("w07_done", a_done, 1'b1);
`else
      chk("w07_done", a_done, 1'b1);
      chk("w07_shen_low", a_shift_en, 1'b0);
`endif
      step(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
